// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter
// Shares one DRAM_conRV user interface between two masters (port 0 = CPU
// bus, port 1 = DMA/loader). Each port latches one outstanding request.
// A small FSM grants the controller, pulses its rd/wr enable for one
// cycle, follows the controller's busy handshake and hands read data plus
// a one-cycle done pulse back to the owning port.
//
// Ports:
//   clk, rst_x                  clock, asynchronous active-low reset
//   pN_rd_en/pN_wr_en           one-cycle request strobes (N = 0, 1)
//   pN_addr/pN_wdata/pN_ctrl    request payload
//   pN_rdata/pN_busy/pN_done    registered read data, pending flag, completion pulse
//   m_rd_en/m_wr_en/m_addr/m_wdata/m_ctrl   controller request side
//   m_rdata/m_busy/m_init_done  controller response and status
//   grant_id                    port owning the current or last transaction
//   timeout_err                 sticky watchdog flag
//   arb_state                   FSM state for debug
module dram_req_arbiter #(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        p0_rd_en,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_ctrl,
  output logic [31:0] p0_rdata,
  output logic        p0_busy,
  output logic        p0_done,
  input  logic        p1_rd_en,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_ctrl,
  output logic [31:0] p1_rdata,
  output logic        p1_busy,
  output logic        p1_done,
  output logic        m_rd_en,
  output logic        m_wr_en,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_ctrl,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  input  logic        m_init_done,
  output logic        grant_id,
  output logic        timeout_err,
  output logic [2:0]  arb_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        is_rd_q, is_rd_d;
  logic [1:0][31:0]  addr_q, addr_d;
  logic [1:0][31:0]  wdata_q, wdata_d;
  logic [1:0][2:0]   ctrl_q, ctrl_d;
  logic              m_rd_en_q, m_rd_en_d, m_wr_en_q, m_wr_en_d;
  logic [31:0]       m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [2:0]        m_ctrl_q, m_ctrl_d;
  logic              gid_q, gid_d;
  logic [1:0]        done_q, done_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
  logic              win;

  logic [1:0]        req_rd, req_wr, clr;
  logic [1:0][31:0]  req_addr, req_wdata;
  logic [1:0][2:0]   req_ctrl;

  assign req_rd    = {p1_rd_en, p0_rd_en};
  assign req_wr    = {p1_wr_en, p0_wr_en};
  assign req_addr  = {p1_addr, p0_addr};
  assign req_wdata = {p1_wdata, p0_wdata};
  assign req_ctrl  = {p1_ctrl, p0_ctrl};

  // The granted port's pending bit is released as the FSM leaves DONE.
  assign clr = (state_q == DONE) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;

  // Per-port request latch: accept only when not already pending; a read wins a rd+wr collision.
  always_comb begin
    pend_d  = pend_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    for (int p = 0; p < 2; p++) begin
      if ((req_rd[p] || req_wr[p]) && !pend_q[p]) begin
        pend_d[p]  = 1'b1;
        is_rd_d[p] = req_rd[p];
        addr_d[p]  = req_addr[p];
        wdata_d[p] = req_wdata[p];
        ctrl_d[p]  = req_ctrl[p];
      end else if (clr[p]) begin
        pend_d[p] = 1'b0;
      end else begin
        pend_d[p] = pend_q[p];
      end
    end
  end

  // Arbitration, controller handshake sequencing and watchdog.
  always_comb begin
    state_d   = state_q;
    m_rd_en_d = 1'b0;
    m_wr_en_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_ctrl_d  = m_ctrl_q;
    gid_d     = gid_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    wd_d      = wd_q;
    to_d      = to_q;
    // On a tie round-robin favours the port that did not own the last grant.
    if (pend_q == 2'b11) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~gid_q;
    end else begin
      win = pend_q[1];
    end
    case (state_q)
      IDLE: begin
        if (m_init_done && !m_busy && (pend_q != 2'b00)) begin
          gid_d     = win;
          m_addr_d  = addr_q[win];
          m_wdata_d = wdata_q[win];
          m_ctrl_d  = ctrl_q[win];
          m_rd_en_d = is_rd_q[win];
          m_wr_en_d = ~is_rd_q[win];
          wd_d      = '0;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (wd_q != WD_LIMIT) begin
          wd_d = wd_q + WD_W'(1);
        end else begin
          wd_d = wd_q;
        end
        // The transaction is never aborted; the flag only records the overrun.
        if (wd_d == WD_LIMIT) begin
          to_d = 1'b1;
        end else begin
          to_d = to_q;
        end
        if (state_q == WAIT_BUSY) begin
          if (m_busy) begin
            state_d = WAIT_DONE;
          end else begin
            state_d = WAIT_BUSY;
          end
        end else if (!m_busy) begin
          // Result and done pulse are registered here so they are valid during DONE.
          state_d       = DONE;
          done_d[gid_q] = 1'b1;
          if (is_rd_q[gid_q]) begin
            rdata_d[gid_q] = m_rdata;
          end else begin
            rdata_d[gid_q] = rdata_q[gid_q];
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; grant_id resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= IDLE;
      pend_q    <= 2'b00;
      is_rd_q   <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= '0;
      m_rd_en_q <= 1'b0;
      m_wr_en_q <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      m_ctrl_q  <= 3'd0;
      gid_q     <= 1'b1;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      wd_q      <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ctrl_q    <= ctrl_d;
      m_rd_en_q <= m_rd_en_d;
      m_wr_en_q <= m_wr_en_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_ctrl_q  <= m_ctrl_d;
      gid_q     <= gid_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      wd_q      <= wd_d;
      to_q      <= to_d;
    end
  end

  assign p0_rdata    = rdata_q[0];
  assign p1_rdata    = rdata_q[1];
  assign p0_busy     = pend_q[0];
  assign p1_busy     = pend_q[1];
  assign p0_done     = done_q[0];
  assign p1_done     = done_q[1];
  assign m_rd_en     = m_rd_en_q;
  assign m_wr_en     = m_wr_en_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_ctrl      = m_ctrl_q;
  assign grant_id    = gid_q;
  assign timeout_err = to_q;
  assign arb_state   = state_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Bench for dram_req_arbiter: two instances (round-robin and fixed priority)
// each driven against a small DRAM controller model. A transaction-level
// reference model predicts acceptance, grant order and timing; a monitor
// process scoreboards every controller request and port completion.
module tb_dram_req_arbiter;
  localparam int TO    = 16;
  localparam int NEVER = 32'h7fff_ffff;

  typedef struct {
    bit          rd;
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  c;
  } txn_t;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic init_done = 1'b1;
  always #5 clk = ~clk;

  logic        rd_en [2][2];
  logic        wr_en [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [2:0]  ctrl  [2][2];
  logic [31:0] p_rdata [2][2];
  logic        p_busy  [2][2];
  logic        p_done  [2][2];
  logic        m_rd [2];
  logic        m_wr [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [2:0]  m_ctrl [2];
  logic [31:0] m_rdata [2];
  logic        m_busy [2];
  logic        gid [2];
  logic        to_err [2];
  logic [2:0]  st [2];

  int busy_len  = 5;
  bit busy_hold = 1'b0;
  int stim_err  = 0;
  bit end_req   = 1'b0;

  // Controller read data is a fixed function of the address.
  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hCAFE_BABE;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    logic [7:0] bcnt;
    dram_req_arbiter #(.FIXED_PRIO(k), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_x(rst_x),
      .p0_rd_en(rd_en[k][0]), .p0_wr_en(wr_en[k][0]), .p0_addr(addr[k][0]),
      .p0_wdata(wdata[k][0]), .p0_ctrl(ctrl[k][0]), .p0_rdata(p_rdata[k][0]),
      .p0_busy(p_busy[k][0]), .p0_done(p_done[k][0]),
      .p1_rd_en(rd_en[k][1]), .p1_wr_en(wr_en[k][1]), .p1_addr(addr[k][1]),
      .p1_wdata(wdata[k][1]), .p1_ctrl(ctrl[k][1]), .p1_rdata(p_rdata[k][1]),
      .p1_busy(p_busy[k][1]), .p1_done(p_done[k][1]),
      .m_rd_en(m_rd[k]), .m_wr_en(m_wr[k]), .m_addr(m_addr[k]), .m_wdata(m_wdata[k]),
      .m_ctrl(m_ctrl[k]), .m_rdata(m_rdata[k]), .m_busy(m_busy[k]),
      .m_init_done(init_done), .grant_id(gid[k]), .timeout_err(to_err[k]),
      .arb_state(st[k]));
    assign m_busy[k]  = (bcnt != 8'd0);
    assign m_rdata[k] = rdata_fn(m_addr[k]);
    // Controller model: busy for busy_len cycles starting the cycle after an enable.
    always @(posedge clk or negedge rst_x) begin
      if (!rst_x) bcnt <= 8'd0;
      else if (m_rd[k] || m_wr[k]) bcnt <= 8'(busy_len);
      else if (bcnt != 8'd0 && !busy_hold) bcnt <= bcnt - 8'd1;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  txn_t sbq [4][$];
  bit [1:0]    mp [2];
  bit          act [2];
  int          en_due [2];
  int          done_due [2];
  int          wait_start [2];
  bit          win [2];
  bit          last_g [2];
  bit          to_exp [2];
  logic [31:0] last_rd [2][2];
  txn_t        cur [2];

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %h expected %h", nm, k, cyc, a, e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mp[k] = 2'b00; act[k] = 1'b0; en_due[k] = NEVER; done_due[k] = NEVER;
      wait_start[k] = NEVER; last_g[k] = 1'b1; to_exp[k] = 1'b0;
      last_rd[k][0] = 32'd0; last_rd[k][1] = 32'd0;
      sbq[2*k].delete(); sbq[2*k+1].delete();
    end
  endtask

  initial begin : monitor
    bit en_a, en_e, d_a, d_e, w;
    bit [1:0] nmp;
    logic [31:0] exp_rd;
    int wt;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (end_req || cyc > 90000) begin
        if (cyc > 90000) chk("run_bound", 0, 32'(cyc), 32'd90000);
        chk("stim_wait_bound", 0, 32'(stim_err), 32'd0);
        chk("sb_drained", 0, 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
      if (!rst_x) begin
        for (int k = 0; k < 2; k++) begin
          chk("rst_outputs_zero", k, 32'(|{m_rd[k], m_wr[k], m_addr[k], m_wdata[k], m_ctrl[k],
              to_err[k], p_busy[k][0], p_busy[k][1], p_done[k][0], p_done[k][1],
              p_rdata[k][0], p_rdata[k][1]}), 32'd0);
          chk("rst_arb_state", k, 32'(st[k]), 32'd0);
          chk("rst_grant_id", k, 32'(gid[k]), 32'd1);
        end
        model_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          for (int p = 0; p < 2; p++)
            chk($sformatf("p%0d_busy", p), k, 32'(p_busy[k][p]), 32'(mp[k][p]));
          en_a = m_rd[k] | m_wr[k];
          en_e = (en_due[k] == cyc);
          if (en_a || en_e) chk("m_en_timing", k, 32'(en_a), 32'(en_e));
          if (en_a && en_e) begin
            chk("m_en_type", k, 32'({m_rd[k], m_wr[k]}), cur[k].rd ? 32'd2 : 32'd1);
            chk("m_addr", k, m_addr[k], cur[k].a);
            chk("m_wdata", k, m_wdata[k], cur[k].w);
            chk("m_ctrl", k, 32'(m_ctrl[k]), 32'(cur[k].c));
            chk("grant_id", k, 32'(gid[k]), 32'(win[k]));
            done_due[k]   = busy_hold ? NEVER : cyc + busy_len + 2;
            wait_start[k] = cyc + 1;
          end
          for (int p = 0; p < 2; p++) begin
            d_a = p_done[k][p];
            d_e = (done_due[k] == cyc) && (win[k] == p[0]);
            if (d_a || d_e) chk($sformatf("p%0d_done", p), k, 32'(d_a), 32'(d_e));
            if (d_e) begin
              exp_rd = cur[k].rd ? rdata_fn(cur[k].a) : last_rd[k][p];
              chk($sformatf("p%0d_rdata", p), k, p_rdata[k][p], exp_rd);
              chk("m_addr_hold", k, m_addr[k], cur[k].a);
              last_rd[k][p] = exp_rd;
            end
          end
          if (to_exp[k]) begin
            chk("timeout_sticky", k, 32'(to_err[k]), 32'd1);
          end else if (act[k] && wait_start[k] != NEVER && cyc >= wait_start[k]) begin
            wt = cyc - wait_start[k] + 1;
            if (wt <= TO - 1) chk("timeout_early", k, 32'(to_err[k]), 32'd0);
            else if (wt >= TO + 2) begin
              chk("timeout_set", k, 32'(to_err[k]), 32'd1);
              to_exp[k] = 1'b1;
            end
          end
          // next-cycle model state
          nmp = mp[k];
          for (int p = 0; p < 2; p++) begin
            if ((rd_en[k][p] || wr_en[k][p]) && !mp[k][p]) begin
              sbq[2*k+p].push_back('{rd_en[k][p], addr[k][p], wdata[k][p], ctrl[k][p]});
              nmp[p] = 1'b1;
            end
          end
          if (done_due[k] == cyc) begin
            nmp[win[k]] = 1'b0;
            act[k] = 1'b0;
            done_due[k] = NEVER;
            wait_start[k] = NEVER;
          end else if (!act[k] && init_done && !m_busy[k] && mp[k] != 2'b00) begin
            if (mp[k] == 2'b11) w = (k == 1) ? 1'b0 : !last_g[k];
            else w = mp[k][1];
            if (sbq[2*k+w].size() != 0) cur[k] = sbq[2*k+w].pop_front();
            win[k] = w; last_g[k] = w; act[k] = 1'b1; en_due[k] = cyc + 1;
          end
          mp[k] = nmp;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        rd_en[k][p] = 1'b0; wr_en[k][p] = 1'b0;
      end
  endtask

  task automatic strobe(input int p, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] c);
    for (int k = 0; k < 2; k++) begin
      rd_en[k][p] = rd; wr_en[k][p] = wr; addr[k][p] = a; wdata[k][p] = wd; ctrl[k][p] = c;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    clear_strobes();
    while ((p_busy[0][0] || p_busy[0][1] || p_busy[1][0] || p_busy[1][1]) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) stim_err++;
    tick(); tick();
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    tick(); tick();
    rst_x = 1'b1;
    tick();
  endtask

  initial begin : stim
    bit re [2];
    int nre [2];
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        rd_en[k][p] = 1'b0; wr_en[k][p] = 1'b0; addr[k][p] = 32'd0;
        wdata[k][p] = 32'd0; ctrl[k][p] = 3'd0;
      end
    tick(); tick();
    rst_x = 1'b1;
    tick();
    // single read on port 0
    busy_len = 5;
    strobe(0, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 3'd2);
    tick();
    wait_idle();
    // simultaneous write p0 / read p1, three rounds, fresh arbitration history
    do_reset();
    for (int r = 0; r < 3; r++) begin
      strobe(0, 1'b0, 1'b1, 32'h0000_0200, $urandom, 3'd2);
      strobe(1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 3'd2);
      tick();
      wait_idle();
    end
    // port 0 re-requests in the cycle after each done while port 1 waits
    strobe(0, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 3'd2);
    strobe(1, 1'b0, 1'b1, 32'h0000_0480, 32'h1234_5678, 3'd1);
    re[0] = 1'b0; re[1] = 1'b0; nre[0] = 0; nre[1] = 0;
    tick();
    clear_strobes();
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 2; k++) begin
        rd_en[k][0] = re[k];
        addr[k][0]  = 32'h0000_0400 + 32'(4 * i);
        if (re[k]) nre[k]++;
        re[k] = p_done[k][0] && (nre[k] < 3);
      end
      tick();
    end
    wait_idle();
    // init gating
    init_done = 1'b0;
    strobe(1, 1'b1, 1'b0, 32'h0000_0500, 32'd0, 3'd4);
    tick();
    clear_strobes();
    repeat (50) tick();
    init_done = 1'b1;
    wait_idle();
    // rd+wr collision, then a strobe while busy
    strobe(0, 1'b1, 1'b1, 32'h0000_0600, 32'hDEAD_0001, 3'd2);
    tick();
    strobe(0, 1'b0, 1'b1, 32'h0000_0700, 32'hDEAD_0002, 3'd2);
    tick();
    wait_idle();
    // watchdog with a stuck controller, then reset mid-wait
    busy_hold = 1'b1;
    strobe(0, 1'b1, 1'b0, 32'h0000_0800, 32'd0, 3'd2);
    tick();
    clear_strobes();
    repeat (30) tick();
    rst_x = 1'b0;
    tick(); tick();
    busy_hold = 1'b0;
    rst_x = 1'b1;
    tick();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      busy_len  = $urandom_range(1, 8);
      init_done = ($urandom_range(0, 15) != 0);
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          if ($urandom_range(0, 3) == 0) begin
            rd_en[k][p] = $urandom_range(0, 1) == 1;
            wr_en[k][p] = $urandom_range(0, 1) == 1;
          end else begin
            rd_en[k][p] = 1'b0;
            wr_en[k][p] = 1'b0;
          end
          addr[k][p]  = $urandom & 32'hFFFF_FFFC;
          wdata[k][p] = $urandom;
          ctrl[k][p]  = 3'($urandom_range(0, 7));
        end
      tick();
    end
    init_done = 1'b1;
    wait_idle();
    end_req = 1'b1;
  end

endmodule

// File: doc/dram_req_arbiter.md
# dram_req_arbiter

Two-port request arbiter in front of the `DRAM_conRV` user interface. It shares the single DRAM controller between the CPU bus (port 0) and a secondary master such as a DMA or disk loader (port 1). It latches one outstanding request per port and grants the controller round-robin or by fixed priority. It sequences the controller's rd/wr-enable and busy handshake, then returns read data and a completion pulse to the owning port.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = port 0 always wins a simultaneous request.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit on cycles spent in WAIT_BUSY+WAIT_DONE for one transaction.
- `clk  in  1`: single clock, shared with `DRAM_conRV`.
- `rst_x  in  1`: reset, asynchronous and active-low.
- `pN_rd_en, pN_wr_en  in  1`: one-cycle request strobes, N = 0, 1.
- `pN_addr  in  32`: byte address of the request.
- `pN_wdata  in  32`: write data.
- `pN_ctrl  in  3`: size and sign code, same encoding as the controller's `i_ctrl`.
- `pN_rdata  out  32`: read data, registered.
- `pN_busy  out  1`: port has a pending or in-flight request.
- `pN_done  out  1`: one-cycle completion pulse.
- `m_rd_en, m_wr_en  out  1`: to controller `i_rd_en` / `i_wr_en`.
- `m_addr, m_wdata  out  32`: to controller `i_addr` / `i_data`.
- `m_ctrl  out  3`: to controller `i_ctrl`.
- `m_rdata  in  32`: from controller `o_data`.
- `m_busy  in  1`: from controller `o_busy`.
- `m_init_done  in  1`: from controller `o_init_calib_complete`.
- `grant_id  out  1`: port owning the current or last transaction.
- `timeout_err  out  1`: sticky watchdog flag.
- `arb_state  out  3`: FSM state, for debug.

## Operation
- Per-port latch:
  - A strobe is accepted only when `pN_busy`=0. The latch captures addr, wdata, ctrl and the type.
  - If rd_en and wr_en are both high in the same cycle, the request is a read and the write is dropped.
  - Strobes while `pN_busy`=1 are ignored.
- `pN_busy` = pending | in-flight. It is registered, so it goes high the cycle after the accepted strobe.
- The FSM states are IDLE(0), ISSUE(1), WAIT_BUSY(2), WAIT_DONE(3), DONE(4).
- IDLE:
  - Grants only if `m_init_done`=1, `m_busy`=0 and at least one port is pending.
  - Grant winner:
    - Only one port pending: that port.
    - Both pending, `FIXED_PRIO`=1: port 0.
    - Both pending, `FIXED_PRIO`=0: the port other than `grant_id`.
  - Loads m_addr, m_wdata and m_ctrl from the winner's latch and sets the matching m_rd_en or m_wr_en. Moves to ISSUE.
- ISSUE: drops m_rd_en and m_wr_en after exactly one cycle high. Goes to WAIT_BUSY.
- WAIT_BUSY: waits for `m_busy`=1, then goes to WAIT_DONE.
- WAIT_DONE: waits for `m_busy`=0, then goes to DONE.
- DONE:
  - For reads, latches `m_rdata` into the granted port's `pN_rdata`. For writes, `pN_rdata` is unchanged.
  - Pulses `pN_done`, clears that port's pending bit, and returns to IDLE.
- m_addr, m_wdata and m_ctrl are held stable from IDLE exit until DONE exits.
- Watchdog:
  - Counts cycles in WAIT_BUSY and WAIT_DONE; it resets on each grant.
  - On reaching `TIMEOUT_CYCLES`, sets `timeout_err`, which stays set until reset. The FSM keeps waiting; the transaction is not aborted.
- Requests arriving before `m_init_done` stay pending and issue in order of arbitration once init completes.
- A port may issue a new strobe in the cycle after its `pN_done`. The other port's pending request is not blocked by that.

## Timing
- Reset values (asynchronous on `rst_x`=0):
  - All outputs are 0, with state IDLE and `grant_id`=1, so port 0 wins the first round-robin tie.
  - Pending latches and the watchdog are cleared.
- Reset mid-transaction: `m_rd_en` and `m_wr_en` drop immediately and the pending request is lost. The controller shares `rst_x`.
- Strobe in cycle t, arbiter idle, controller idle:
  - t+1: pending, `pN_busy`=1, grant decided.
  - t+2: m_*_en=1.
  - t+3: `m_busy` seen high (the controller registers its stall).
  - `pN_done` and `pN_rdata` become valid one cycle after `m_busy` falls.
  - `pN_busy` falls one cycle after `pN_done`.
- Overhead beyond controller busy time: 3 cycles (ISSUE, WAIT_BUSY, DONE), plus 1 accept cycle.
- A back-to-back grant to the other port occurs in the IDLE cycle immediately after DONE.

## Test plan
- Single read, port 0: m_init_done=1, p0 read addr 0x100, ctrl=2; model returns 0xCAFEBABE after 5 busy cycles.
  - Expect m_rd_en high exactly one cycle at t+2 with m_addr=0x100.
  - Expect p0_done one pulse and p0_rdata=0xCAFEBABE.
- Simultaneous requests, round-robin (FIXED_PRIO=0): p0 write 0x200 and p1 read 0x300 in the same cycle, repeated 3 times.
  - Expect grants in the order p0, p1, p0, p1, p0, p1.
  - Expect exactly one m_*_en per transaction and no overlap.
- Same as above with FIXED_PRIO=1 and p0 re-requesting right after each done.
  - Expect p0 to win every tie.
  - Expect p1 to be granted only when p0 is not pending.
- Init gating: m_init_done=0, p1 read.
  - Expect p1_busy=1 and no m_rd_en for 50 cycles.
  - Raise m_init_done; expect m_rd_en 1 cycle later.
- Collision and ignore rules:
  - p0 strobes rd_en and wr_en together: expect a read issued.
  - p0 strobes again while p0_busy=1: expect it ignored, with exactly one transaction.
- Watchdog and reset: model holds m_busy=1 with TIMEOUT_CYCLES=16.
  - Expect timeout_err=1 at cycle 16 of waiting, and it stays set.
  - Assert rst_x=0 mid-wait: expect all outputs 0 asynchronously and arb_state=0.
